// File: rtl/pipe_stage_buf.sv
// Inter-stage pipeline register with valid/ready handshake, optional 2-entry skid buffer,
// synchronous flush and a saturating back-pressure counter. Empty slots present all-zero payload.
module pipe_stage_buf #(
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned PC_W    = 32,
   parameter int unsigned SIDE_W  = 8,
   parameter int unsigned SKID    = 1,
   parameter int unsigned STALL_W = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [DATA_W-1:0]  in_instr,
   input  logic [PC_W-1:0]    in_pc,
   input  logic [SIDE_W-1:0]  in_side,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [DATA_W-1:0]  out_instr,
   output logic [PC_W-1:0]    out_pc,
   output logic [SIDE_W-1:0]  out_side,
   output logic [1:0]         occupancy,
   output logic [STALL_W-1:0] stall_cnt
);

   localparam int unsigned ENT_W = DATA_W + PC_W + SIDE_W;

   logic [ENT_W-1:0]   m_data_q, m_data_d, s_data_q, s_data_d, in_data;
   logic               m_valid_q, m_valid_d, s_valid_q, s_valid_d;
   logic [STALL_W-1:0] stall_q, stall_d;
   logic               in_fire, out_fire;

   assign in_data  = {in_instr, in_pc, in_side};
   // With the skid entry, ready depends only on state, cutting the combinational path from out_ready
   assign in_ready = (SKID != 0) ? !s_valid_q : (!m_valid_q || out_ready);
   assign in_fire  = in_valid && in_ready;
   assign out_fire = m_valid_q && out_ready;

   always_comb begin
      m_valid_d = m_valid_q;
      m_data_d  = m_data_q;
      s_valid_d = s_valid_q;
      s_data_d  = s_data_q;
      if (flush) begin
         m_valid_d = 1'b0;
         m_data_d  = '0;
         s_valid_d = 1'b0;
         s_data_d  = '0;
      end else if (!m_valid_q || out_fire) begin
         if (s_valid_q) begin
            // Skid entry is older than any same-cycle input, so it advances first
            m_valid_d = 1'b1;
            m_data_d  = s_data_q;
            s_valid_d = in_fire;
            s_data_d  = in_fire ? in_data : '0;
         end else if (in_fire) begin
            m_valid_d = 1'b1;
            m_data_d  = in_data;
         end else begin
            m_valid_d = 1'b0;
            m_data_d  = '0;
         end
      end else if (in_fire && (SKID != 0)) begin
         s_valid_d = 1'b1;
         s_data_d  = in_data;
      end
   end

   always_comb begin
      stall_d = stall_q;
      if (m_valid_q && !out_ready && (stall_q != '1))
         stall_d = stall_q + STALL_W'(1);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_valid_q <= 1'b0;
         m_data_q  <= '0;
         s_valid_q <= 1'b0;
         s_data_q  <= '0;
         stall_q   <= '0;
      end else begin
         m_valid_q <= m_valid_d;
         m_data_q  <= m_data_d;
         s_valid_q <= s_valid_d;
         s_data_q  <= s_data_d;
         stall_q   <= stall_d;
      end
   end

   assign out_valid = m_valid_q;
   assign out_instr = m_data_q[ENT_W-1 -: DATA_W];
   assign out_pc    = m_data_q[SIDE_W +: PC_W];
   assign out_side  = m_data_q[SIDE_W-1:0];
   assign occupancy = {1'b0, m_valid_q} + {1'b0, s_valid_q};
   assign stall_cnt = stall_q;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: a SKID=1 instance and a SKID=0/STALL_W=4 instance, each checked
// every cycle against a FIFO-list reference model, plus directed literal expectations.
module tb_pipe_stage_buf;

   logic        clk = 1'b0;
   logic        reset, flush;
   logic        ivld[2], ordy[2], irdy[2], ovld[2];
   logic [31:0] iinstr[2], ipc[2], oinstr[2], opc[2];
   logic [7:0]  iside[2], oside[2];
   logic [1:0]  occ[2];
   logic [15:0] ocnt0;
   logic [3:0]  ocnt1;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   // Reference: list of held entries, oldest first; mn entries valid
   logic [71:0] mfifo[2][2];
   int          mn[2]   = '{0, 0};
   int          mcnt[2] = '{0, 0};

   always #5 clk = ~clk;

   pipe_stage_buf #(.DATA_W(32), .PC_W(32), .SIDE_W(8), .SKID(1), .STALL_W(16)) dut0 (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(ivld[0]), .in_ready(irdy[0]), .in_instr(iinstr[0]), .in_pc(ipc[0]), .in_side(iside[0]),
      .out_valid(ovld[0]), .out_ready(ordy[0]), .out_instr(oinstr[0]), .out_pc(opc[0]), .out_side(oside[0]),
      .occupancy(occ[0]), .stall_cnt(ocnt0));

   pipe_stage_buf #(.DATA_W(32), .PC_W(32), .SIDE_W(8), .SKID(0), .STALL_W(4)) dut1 (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(ivld[1]), .in_ready(irdy[1]), .in_instr(iinstr[1]), .in_pc(ipc[1]), .in_side(iside[1]),
      .out_valid(ovld[1]), .out_ready(ordy[1]), .out_instr(oinstr[1]), .out_pc(opc[1]), .out_side(oside[1]),
      .occupancy(occ[1]), .stall_cnt(ocnt1));

   function automatic bit mready(int k);
      if (k == 0) return mn[0] < 2;
      return (mn[1] == 0) || ordy[1];
   endfunction

   function automatic bit mpop(int k);
      return (mn[k] > 0) && ordy[k];
   endfunction

   function automatic bit mpush(int k);
      return ivld[k] && mready(k);
   endfunction

   // Element idx of the list after removing the delivered head and appending the input
   function automatic logic [71:0] after(int k, int idx);
      int src;
      src = idx + int'(mpop(k));
      if (src < mn[k]) return mfifo[k][src];
      return {iinstr[k], ipc[k], iside[k]};
   endfunction

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int k = 0; k < 2; k++) begin
            mn[k]   <= 0;
            mcnt[k] <= 0;
         end
      end else begin
         for (int k = 0; k < 2; k++) begin
            if ((mn[k] > 0) && !ordy[k] && (mcnt[k] < ((k == 0) ? 65535 : 15)))
               mcnt[k] <= mcnt[k] + 1;
            if (flush) begin
               mn[k] <= 0;
            end else begin
               mn[k]       <= mn[k] - int'(mpop(k)) + int'(mpush(k));
               mfifo[k][0] <= after(k, 0);
               mfifo[k][1] <= after(k, 1);
            end
         end
      end
   end

   task automatic chk(string nm, int k, logic [71:0] act, logic [71:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s dut%0d actual=%h expected=%h t=%0t", nm, k, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         #1;
         for (int k = 0; k < 2; k++) begin
            logic [71:0] head;
            head = (mn[k] > 0) ? mfifo[k][0] : 72'd0;
            chk("out_valid", k, ovld[k], (mn[k] > 0) ? 72'd1 : 72'd0);
            chk("out_payload", k, {oinstr[k], opc[k], oside[k]}, head);
            chk("occupancy", k, occ[k], 72'(mn[k]));
            chk("in_ready", k, irdy[k], mready(k) ? 72'd1 : 72'd0);
            chk("stall_cnt", k, (k == 0) ? 72'(ocnt0) : 72'(ocnt1), 72'(mcnt[k]));
         end
      end
   end

   task automatic step();
      @(negedge clk);
      #2;
   endtask

   task automatic drive(int k, bit v, logic [31:0] ins);
      ivld[k]   = v;
      iinstr[k] = ins;
      ipc[k]    = ins + 32'h100;
      iside[k]  = ins[7:0];
   endtask

   initial begin
      reset = 1'b1;
      flush = 1'b0;
      for (int k = 0; k < 2; k++) begin
         drive(k, 1'b0, 32'd0);
         ordy[k] = 1'b1;
      end
      #3;
      reset  = 1'b0;
      chk_en = 1'b1;

      // Reset holds everything empty even with in_valid asserted
      drive(0, 1'b1, 32'hDEAD_BEEF);
      drive(1, 1'b1, 32'hDEAD_BEEF);
      step();
      step();
      for (int k = 0; k < 2; k++) begin
         chk("rst_valid", k, ovld[k], 72'd0);
         chk("rst_instr", k, oinstr[k], 72'd0);
         chk("rst_occ", k, occ[k], 72'd0);
         chk("rst_ready", k, irdy[k], 72'd1);
         drive(k, 1'b0, 32'd0);
      end
      reset = 1'b1;

      // Back-to-back stream with one cycle latency
      for (int i = 1; i <= 5; i++) begin
         step();
         for (int k = 0; k < 2; k++) begin
            if (i > 1) chk("stream", k, oinstr[k], 72'(32'h2408_0000 + 32'(i - 1)));
            if (i <= 4) drive(k, 1'b1, 32'h2408_0000 + 32'(i));
            else        drive(k, 1'b0, 32'd0);
         end
      end
      chk("stream_stall", 0, ocnt0, 72'd0);
      chk("stream_stall", 1, ocnt1, 72'd0);
      step();

      // Back-pressure into the skid entry
      drive(0, 1'b1, 32'h2408_0011);
      step();
      ordy[0] = 1'b0;
      drive(0, 1'b1, 32'h2408_0012);
      step();
      chk("bp_occ", 0, occ[0], 72'd2);
      chk("bp_ready", 0, irdy[0], 72'd0);
      chk("bp_head", 0, oinstr[0], 72'h2408_0011);
      drive(0, 1'b1, 32'h2408_0013);
      step();
      chk("bp_occ_hold", 0, occ[0], 72'd2);
      chk("bp_head_hold", 0, oinstr[0], 72'h2408_0011);
      chk("bp_stall", 0, ocnt0, 72'd2);
      ordy[0] = 1'b1;
      step();
      chk("bp_order2", 0, oinstr[0], 72'h2408_0012);
      chk("bp_ready_back", 0, irdy[0], 72'd1);
      step();
      chk("bp_order3", 0, oinstr[0], 72'h2408_0013);
      drive(0, 1'b0, 32'd0);
      step();
      chk("bp_drained", 0, ovld[0], 72'd0);
      chk("bp_stall_final", 0, ocnt0, 72'd2);

      // Flush with both entries held; the flush-cycle input must never appear
      ordy[0] = 1'b0;
      drive(0, 1'b1, 32'h2408_0021);
      step();
      drive(0, 1'b1, 32'h2408_0022);
      step();
      chk("fl_occ_before", 0, occ[0], 72'd2);
      flush = 1'b1;
      drive(0, 1'b1, 32'h0000_000C);
      step();
      chk("fl_occ", 0, occ[0], 72'd0);
      chk("fl_valid", 0, ovld[0], 72'd0);
      chk("fl_instr", 0, oinstr[0], 72'd0);
      chk("fl_stall", 0, ocnt0, 72'd4);
      flush = 1'b0;
      drive(0, 1'b0, 32'd0);
      ordy[0] = 1'b1;
      step();
      chk("fl_no_0c", 0, ovld[0], 72'd0);

      // Saturation on the 4-bit counter
      ordy[1] = 1'b0;
      drive(1, 1'b1, 32'h2408_0031);
      step();
      drive(1, 1'b0, 32'd0);
      repeat (20) step();
      chk("sat_cnt", 1, ocnt1, 72'd15);
      chk("sat_valid", 1, ovld[1], 72'd1);
      step();
      step();
      chk("sat_hold", 1, ocnt1, 72'd15);
      ordy[1] = 1'b1;
      step();
      step();

      // SKID=0: ready tracks out_ready while full
      for (int i = 0; i < 16; i++) begin
         step();
         if (ovld[1]) chk("ready_follows", 1, irdy[1], 72'(ordy[1]));
         ordy[1] = (i % 2) == 0;
         drive(1, 1'b1, 32'h0000_3000 + 32'(i));
      end

      // Randomized traffic on both instances
      repeat (3000) begin
         step();
         for (int k = 0; k < 2; k++) begin
            ordy[k] = ($urandom_range(0, 3) != 0);
            drive(k, 1'($urandom_range(0, 1)), $urandom);
         end
         flush = ($urandom_range(0, 31) == 0);
         if (!reset) reset = 1'b1;
         else if ($urandom_range(0, 499) == 0) reset = 1'b0;
      end
      step();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
